// File: rtl/ysyx_25040129_lsu.sv
// Load/store unit: takes one request from execute, runs a single memory
// transaction and returns writeback data plus a one-cycle completion pulse.
module ysyx_25040129_lsu #(
  parameter int REGS_DIG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_load,
  input  logic                is_store,
  input  logic [2:0]          funct3,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic [REGS_DIG-1:0] rd,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wmask,
  input  logic                mem_resp_valid,
  input  logic                mem_resp_err,
  input  logic [31:0]         mem_rdata,
  output logic                wb_reg_write,
  output logic [REGS_DIG-1:0] wb_rd,
  output logic [31:0]         wb_result,
  output logic                done,
  output logic                fault,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1; the valid side holds its payload stable until then.
  typedef enum logic [1:0] {IDLE, REQ, RESP, FIN} state_t;

  state_t                state_q;
  logic                  is_load_q;
  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic [REGS_DIG-1:0]   rd_q;
  logic                  req_valid_q, wen_q, wb_write_q, done_q, fault_q;
  logic [31:0]           addr_q, wdata_q, wb_result_q;
  logic [3:0]            wmask_q;
  logic [REGS_DIG-1:0]   wb_rd_q;

  logic                  illegal;
  logic [3:0]            st_mask;
  logic [31:0]           st_data;
  logic [31:0]           rdata_sh;
  logic [31:0]           ld_value;

  always_comb begin
    illegal = (is_load == is_store);
    st_mask = 4'b0000;
    st_data = wdata;
    case (funct3)
      3'b000: begin
        st_mask = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      3'b001: begin
        illegal = illegal | addr[0];
        st_mask = 4'b0011 << {addr[1], 1'b0};
        st_data = {2{wdata[15:0]}};
      end
      3'b010: begin
        illegal = illegal | (addr[1:0] != 2'b00);
        st_mask = 4'b1111;
      end
      3'b100:  illegal = illegal | is_store;
      3'b101:  illegal = illegal | is_store | addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Returned word is shifted so the addressed byte lands in lane 0.
  assign rdata_sh = mem_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    ld_value = rdata_sh;
    case (funct3_q)
      3'b000:  ld_value = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001:  ld_value = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b100:  ld_value = {24'd0, rdata_sh[7:0]};
      3'b101:  ld_value = {16'd0, rdata_sh[15:0]};
      default: ld_value = rdata_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      rd_q        <= '0;
      req_valid_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
      wb_write_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_result_q <= 32'd0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      wb_write_q <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        IDLE: if (in_valid) begin
          if (illegal) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
          end else begin
            state_q     <= REQ;
            is_load_q   <= is_load;
            funct3_q    <= funct3;
            addr_lo_q   <= addr[1:0];
            rd_q        <= rd;
            req_valid_q <= 1'b1;
            wen_q       <= is_store;
            addr_q      <= {addr[31:2], 2'b00};
            wdata_q     <= st_data;
            wmask_q     <= is_store ? st_mask : 4'b0000;
          end
        end
        REQ: if (mem_req_ready) begin
          req_valid_q <= 1'b0;
          state_q     <= RESP;
        end
        RESP: if (mem_resp_valid) begin
          state_q <= FIN;
          done_q  <= 1'b1;
          fault_q <= mem_resp_err;
          if (is_load_q && !mem_resp_err && rd_q != '0) begin
            wb_write_q  <= 1'b1;
            wb_rd_q     <= rd_q;
            wb_result_q <= ld_value;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = req_valid_q;
  assign mem_wen       = wen_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign wb_reg_write  = wb_write_q;
  assign wb_rd         = wb_rd_q;
  assign wb_result     = wb_result_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Bench for the LSU: directed scenarios plus random requests checked against
// a transaction-level model of address alignment, lanes and load extension.
module tb_ysyx_25040129_lsu;
  localparam int RD_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, is_load, is_store;
  logic [2:0]      funct3;
  logic [31:0]     addr, wdata;
  logic [RD_W-1:0] rd;
  logic            mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0]     mem_addr, mem_wdata;
  logic [3:0]      mem_wmask;
  logic            mem_resp_valid, mem_resp_err;
  logic [31:0]     mem_rdata;
  logic            wb_reg_write;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_result;
  logic            done, fault;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0]     exp_q[$];
  logic [31:0]     last_result;
  logic [RD_W-1:0] last_rd;

  ysyx_25040129_lsu #(.REGS_DIG(RD_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rd(rd), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
    .mem_rdata(mem_rdata), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .done(done), .fault(fault), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_illegal(input bit ld, input bit st,
                                       input logic [2:0] f3, input logic [31:0] a);
    int sz = op_size(f3);
    if (ld == st) return 1;
    if (sz == 0) return 1;
    if (st && f3 >= 3'd4) return 1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    logic [31:0] s, r;
    s = rdata >> (8 * (a % 4));
    case (f3)
      3'd0: begin r = s % 256;   if (r >= 128)   r = r - 32'd256;   end
      3'd1: begin r = s % 65536; if (r >= 32768) r = r - 32'd65536; end
      3'd4: r = s % 256;
      3'd5: r = s % 65536;
      default: r = s;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
    int sz = op_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_sdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'd0:    return (w % 256) * 32'h0101_0101;
      3'd1:    return (w % 65536) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_before_op", in_ready, 1);
  endtask

  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w, input logic [RD_W-1:0] r,
                       input int req_delay, input int resp_delay,
                       input logic [31:0] rdata, input bit err);
    bit          ill = model_illegal(ld, st, f3, a);
    bit          exp_wr;
    logic [31:0] e_addr = {a[31:2], 2'b00};
    wait_ready();
    in_valid = 1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = w; rd = r;
    tick();
    // scramble request inputs to prove the DUT holds its own copy
    in_valid = 0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom); rd = RD_W'($urandom);
    if (ill) begin
      check("ill_done", done, 1);
      check("ill_fault", fault, 1);
      check("ill_wb", wb_reg_write, 0);
      check("ill_req_valid", mem_req_valid, 0);
      tick();
      check("ill_done_end", done, 0);
      return;
    end
    for (int k = 0; k <= req_delay; k++) begin
      check("req_valid", mem_req_valid, 1);
      check("req_wen", mem_wen, st);
      check("req_addr", mem_addr, e_addr);
      check("req_wmask", mem_wmask, st ? model_mask(f3, a) : 4'd0);
      if (st) check("req_wdata", mem_wdata, model_sdata(f3, w));
      check("req_no_done", done, 0);
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_err   = 1'($urandom_range(0, 1));
      mem_req_ready  = (k == req_delay);
      tick();
    end
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0;
    check("resp_req_valid", mem_req_valid, 0);
    for (int k = 0; k < resp_delay; k++) begin
      tick();
      check("resp_wait_done", done, 0);
    end
    mem_resp_valid = 1; mem_resp_err = err; mem_rdata = rdata;
    exp_wr = ld && !err && (r != 0);
    if (exp_wr) begin
      exp_q.push_back(model_load(f3, a, rdata));
      last_rd = r;
    end
    tick();
    mem_resp_valid = 0; mem_resp_err = 0; mem_rdata = $urandom;
    check("fin_done", done, 1);
    check("fin_fault", fault, err);
    check("fin_wb", wb_reg_write, exp_wr);
    if (exp_wr) begin
      last_result = exp_q.pop_front();
      check("fin_wb_rd", wb_rd, last_rd);
      check("fin_wb_result", wb_result, last_result);
    end
    tick();
    check("post_done", done, 0);
    check("post_wb", wb_reg_write, 0);
    check("post_fault", fault, 0);
    check("post_hold_result", wb_result, last_result);
    check("post_hold_rd", wb_rd, last_rd);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_req_valid"}, mem_req_valid, 0);
    check({tag, "_wen"}, mem_wen, 0);
    check({tag, "_wmask"}, mem_wmask, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_wb"}, wb_reg_write, 0);
    check({tag, "_wb_rd"}, wb_rd, 0);
    check({tag, "_wb_result"}, wb_result, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fault"}, fault, 0);
  endtask

  task automatic reset_in_flight(input int stop_in_resp);
    wait_ready();
    in_valid = 1; is_load = 1; is_store = 0; funct3 = 3'd2; addr = 32'h100; rd = 4'd3;
    tick();
    in_valid = 0;
    if (stop_in_resp != 0) begin
      mem_req_ready = 1;
      tick();
      mem_req_ready = 0;
    end
    rst = 0;
    tick();
    rst = 1;
    last_result = 0; last_rd = 0;
    check_reset_state("abort");
    mem_resp_valid = 1; mem_resp_err = 0; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 0;
    for (int k = 0; k < 3; k++) begin
      check("late_resp_done", done, 0);
      check("late_resp_wb", wb_reg_write, 0);
      check("late_resp_in_ready", in_ready, 1);
      tick();
    end
  endtask

  initial begin
    rst = 0; in_valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0; rd = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_err = 0; mem_rdata = 0;
    last_result = 0; last_rd = 0;
    tick(); tick();
    rst = 1;
    check_reset_state("reset");

    // stray response while idle is ignored
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    check("idle_resp_done", done, 0);
    check("idle_resp_in_ready", in_ready, 1);

    // lb sign-extended from the top byte
    do_op(1, 0, 3'd0, 32'h8000_0003, 32'h0, 4'd5, 0, 0, 32'h80AA_BBCC, 0);
    // sh to upper half
    do_op(0, 1, 3'd1, 32'h0000_1002, 32'h1234_5678, 4'd7, 0, 0, 32'h0, 0);
    // misaligned lw faults without a memory access
    do_op(1, 0, 3'd2, 32'h0000_1001, 32'h0, 4'd4, 0, 0, 32'h0, 0);
    // lhu with a stalled request
    do_op(1, 0, 3'd5, 32'h0000_2002, 32'h0, 4'd9, 3, 0, 32'h8001_7FFF, 0);
    // reset while in RESP, then while in REQ
    reset_in_flight(1);
    reset_in_flight(0);
    // lw rd0 with error, then without
    do_op(1, 0, 3'd2, 32'h0000_3000, 32'h0, 4'd0, 0, 1, 32'h1111_2222, 1);
    do_op(1, 0, 3'd2, 32'h0000_3000, 32'h0, 4'd0, 0, 0, 32'h1111_2222, 0);
    // other illegal forms
    do_op(1, 1, 3'd0, 32'h0, 32'h0, 4'd1, 0, 0, 32'h0, 0);
    do_op(0, 0, 3'd0, 32'h0, 32'h0, 4'd1, 0, 0, 32'h0, 0);
    do_op(0, 1, 3'd4, 32'h0, 32'h0, 4'd1, 0, 0, 32'h0, 0);
    do_op(1, 0, 3'd3, 32'h0, 32'h0, 4'd1, 0, 0, 32'h0, 0);
    // sb lane 1 and sw
    do_op(0, 1, 3'd0, 32'h0000_4001, 32'hCAFE_F00D, 4'd2, 1, 2, 32'h0, 0);
    do_op(0, 1, 3'd2, 32'h0000_4008, 32'hCAFE_F00D, 4'd2, 0, 1, 32'h0, 0);

    for (int i = 0; i < 200; i++) begin
      bit ld, st;
      if ($urandom_range(0, 9) == 0) begin
        ld = 1'($urandom); st = ld;
      end else begin
        ld = 1'($urandom); st = !ld;
      end
      do_op(ld, st, 3'($urandom), $urandom, $urandom, RD_W'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ysyx_25040129_lsu.md
YSYX_25040129_LSU -- requirements
Module: ysyx_25040129_lsu

Interface
REQ-001 Parameter: REGS_DIG, 4, register-index width, same as the register file's rd port.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low: 0 = reset.
REQ-004 in_valid / in_ready  in / out  1 / 1  request handshake from execute; a request is accepted on a cycle where both are 1.
REQ-005 is_load, is_store  in  1 each  operation select.
REQ-006 funct3  in  3  size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-007 addr  in  32  effective address, computed upstream.
REQ-008 wdata  in  32  store data, taken from src2.
REQ-009 rd  in  REGS_DIG  load destination.
REQ-010 mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake.
REQ-011 mem_wen  out  1  1 = write.
REQ-012 mem_addr  out  32  word-aligned address: {addr[31:2],2'b00}.
REQ-013 mem_wdata  out  32  lane-aligned store data.
REQ-014 mem_wmask  out  4  byte-enable mask.
REQ-015 mem_resp_valid, mem_resp_err, mem_rdata  in  1, 1, 32  memory response.
REQ-016 wb_reg_write, wb_rd, wb_result  out  1, REGS_DIG, 32  feed the register file's reg_write, rd and result ports.
REQ-017 done, fault  out  1, 1  one-cycle completion pulse; fault qualifies done.

Function
REQ-018 FSM states SHALL be IDLE, REQ, RESP and FIN; in_ready SHALL be 1 only in IDLE.
REQ-019 On accept, IDLE SHALL go to REQ and latch addr, funct3, rd, wdata, is_load and is_store.
- Exception: an illegal request goes to FIN with fault set and no memory access.
- Illegal means: is_load == is_store; h/hu with addr[0] = 1; w with addr[1:0] != 0; a store with funct3 in {bu, hu}; any undefined funct3.
REQ-020 In REQ, mem_req_valid SHALL be 1 and mem_wen, mem_addr, mem_wdata and mem_wmask SHALL stay stable until mem_req_ready; REQ SHALL then go to RESP.
REQ-021 In RESP, mem_resp_valid SHALL move the FSM to FIN; mem_resp_valid in any other state SHALL be ignored.
REQ-022 In FIN, done SHALL pulse for 1 cycle and the FSM SHALL return to IDLE.
- For a successful load with rd != 0: wb_reg_write = 1 in the same cycle.
- For a store, a fault, or rd = 0: wb_reg_write = 0.
REQ-023 mem_resp_err = 1 SHALL set fault and suppress writeback.
REQ-024 Store mask and data:
- sb: mask 4'b0001 << addr[1:0], wdata[7:0] replicated into all 4 bytes.
- sh: mask 4'b0011 << {addr[1],1'b0}, wdata[15:0] replicated into both halves.
- sw: mask 4'b1111.
- Loads: mem_wmask = 0 and mem_wen = 0.
REQ-025 Load extraction: shift mem_rdata right by 8*addr[1:0]; b/h sign-extend, bu/hu zero-extend, w passes through.
REQ-026 Minimum latency, with mem_req_ready = 1 and the response one cycle later: accept at cycle 0, REQ at cycle 1, RESP at cycle 2, FIN (done/writeback) at cycle 3.
REQ-027 Outside FIN, wb_reg_write, done and fault SHALL be 0; wb_result and wb_rd SHALL hold their last values.

Reset
REQ-028 While rst = 0 at a rising edge, the block SHALL enter IDLE; in the following cycle it SHALL show:
- in_ready = 1;
- mem_req_valid = 0, mem_wen = 0, mem_wmask = 0, mem_addr = 0, mem_wdata = 0;
- wb_reg_write = 0, wb_rd = 0, wb_result = 0;
- done = 0, fault = 0.
REQ-029 Reset in REQ or RESP SHALL abort the operation with no writeback; a late response arriving after reset SHALL be ignored.

Verification
REQ-030 lb, addr 0x8000_0003, rdata 0x80AA_BBCC, rd 5 -> mem_addr 0x8000_0000; at cycle 3: wb_result 0xFFFF_FF80, wb_reg_write 1, wb_rd 5.
REQ-031 sh, addr 0x1002, wdata 0x1234_5678 -> mem_wen 1, mem_wmask 4'b1100, mem_wdata 0x5678_5678; done pulses; wb_reg_write 0.
REQ-032 lw, addr 0x1001 -> no mem_req_valid; FIN next cycle with done 1, fault 1, wb_reg_write 0.
REQ-033 lhu, addr 0x2002, mem_req_ready low for 3 cycles -> request signals stable throughout; then wb_result 0x0000_8001 from rdata 0x8001_7FFF.
REQ-034 rst = 0 while in RESP, then mem_resp_valid arrives after release -> IDLE, in_ready 1, no done pulse, no writeback.
REQ-035 lw, rd 0, with mem_resp_err = 1, then lw, rd 0, without error -> first: done 1, fault 1; second: done 1, fault 0; wb_reg_write 0 for both.
